// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg : shared ALUOp / funct / ALU control codes and FSM states   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [1:0] ALUOP_R   = 2'b00;
  localparam logic [1:0] ALUOP_ADD = 2'b01;
  localparam logic [1:0] ALUOP_SUB = 2'b10;
  localparam logic [1:0] ALUOP_RSV = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_MUL = 3'b001;
  localparam logic [2:0] CTRL_SUB = 3'b010;
  localparam logic [2:0] CTRL_AND = 3'b011;
  localparam logic [2:0] CTRL_OR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_arbiter_if : two request ports, one result port, busy flag      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [5:0]        req0_funct_i;
  logic [1:0]        req0_aluop_i;
  logic [DATA_W-1:0] req0_a_i;
  logic [DATA_W-1:0] req0_b_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [5:0]        req1_funct_i;
  logic [1:0]        req1_aluop_i;
  logic [DATA_W-1:0] req1_a_i;
  logic [DATA_W-1:0] req1_b_i;

  logic              res_valid_o;
  logic              res_ready_i;
  logic              res_id_o;
  logic [DATA_W-1:0] res_data_o;
  logic [2:0]        res_ctrl_o;
  logic              busy_o;

  modport master (
    output req0_valid_i, req0_funct_i, req0_aluop_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_funct_i, req1_aluop_i, req1_a_i, req1_b_i,
    output res_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  res_valid_o, res_id_o, res_data_o, res_ctrl_o, busy_o
  );

  modport slave (
    input  req0_valid_i, req0_funct_i, req0_aluop_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_funct_i, req1_aluop_i, req1_a_i, req1_b_i,
    input  res_ready_i,
    output req0_ready_o, req1_ready_o,
    output res_valid_o, res_id_o, res_data_o, res_ctrl_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_ctrl_decode : (funct, ALUOp) -> 3-bit ALU control, combinational|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] ctrl
);

  always_comb begin
    ctrl = CTRL_ADD;
    case (aluop)
      ALUOP_ADD, ALUOP_RSV: ctrl = CTRL_ADD;
      ALUOP_SUB:            ctrl = CTRL_SUB;
      ALUOP_R: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_MUL: ctrl = CTRL_MUL;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          default:   ctrl = CTRL_ADD;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_arbiter : round-robin two-port front end to a shared ALU        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);

  state_t            state;
  logic              last_grant;
  logic              grant_ok;
  logic              pick;
  logic              rdy0;
  logic              rdy1;
  logic              accept;
  logic [5:0]        sel_funct;
  logic [1:0]        sel_aluop;
  logic [2:0]        sel_ctrl;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  logic [3:0]        cnt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_ctrl;
  logic              op_id;
  logic [DATA_W-1:0] alu_y;

  logic              res_valid;
  logic              res_id;
  logic [DATA_W-1:0] res_data;
  logic [2:0]        res_ctrl;

  // A grant is only offered when the result slot is free or being freed this cycle.
  always_comb begin
    grant_ok = rst_i && ((state == IDLE) || ((state == DONE) && bus.res_ready_i));
    if (bus.req0_valid_i && bus.req1_valid_i)
      pick = ~last_grant;
    else
      pick = bus.req1_valid_i;
    rdy0      = grant_ok && bus.req0_valid_i && !pick;
    rdy1      = grant_ok && bus.req1_valid_i && pick;
    sel_funct = pick ? bus.req1_funct_i : bus.req0_funct_i;
    sel_aluop = pick ? bus.req1_aluop_i : bus.req0_aluop_i;
    sel_a     = pick ? bus.req1_a_i     : bus.req0_a_i;
    sel_b     = pick ? bus.req1_b_i     : bus.req0_b_i;
  end

  assign accept = rdy0 | rdy1;

  alu_ctrl_decode u_decode (
    .funct (sel_funct),
    .aluop (sel_aluop),
    .ctrl  (sel_ctrl)
  );

  always_comb begin
    case (op_ctrl)
      CTRL_ADD: alu_y = op_a + op_b;
      CTRL_MUL: alu_y = op_a * op_b;
      CTRL_SUB: alu_y = op_a - op_b;
      CTRL_AND: alu_y = op_a & op_b;
      CTRL_OR:  alu_y = op_a | op_b;
      default:  alu_y = op_a + op_b;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= CTRL_ADD;
      op_id      <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_data   <= '0;
      res_ctrl   <= CTRL_ADD;
    end else begin
      // Accepts only happen in IDLE or DONE, so they never collide with the EXEC countdown.
      if (accept) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_ctrl    <= sel_ctrl;
        op_id      <= pick;
        last_grant <= pick;
        cnt        <= (sel_ctrl == CTRL_MUL) ? 4'(MUL_LAT) : 4'd1;
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          if (cnt == 4'd1) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= alu_y;
            res_id    <= op_id;
            res_ctrl  <= op_ctrl;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            res_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready_o = rdy0;
  assign bus.req1_ready_o = rdy1;
  assign bus.res_valid_o  = res_valid;
  assign bus.res_id_o     = res_id;
  assign bus.res_data_o   = res_data;
  assign bus.res_ctrl_o   = res_ctrl;
  assign bus.busy_o       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_arbiter : directed self-checking bench for alu_arbiter       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32), .MUL_LAT(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input logic [1:0] aluop, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b);
    if (!port) begin
      bus.req0_valid_i = 1'b1; bus.req0_aluop_i = aluop; bus.req0_funct_i = funct;
      bus.req0_a_i = a; bus.req0_b_i = b;
    end else begin
      bus.req1_valid_i = 1'b1; bus.req1_aluop_i = aluop; bus.req1_funct_i = funct;
      bus.req1_a_i = a; bus.req1_b_i = b;
    end
  endtask

  task automatic idle_reqs();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.res_ready_i = 1'b0;
    set_req(0, 2'b01, 6'b000000, 32'd1, 32'd2);
    set_req(1, 2'b01, 6'b000000, 32'd3, 32'd4);
    repeat (3) step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid_o); end
    compared++; if (bus.res_id_o !== 1'b0) begin mismatched++; $display("FAIL reset_res_id: got %b want 0", bus.res_id_o); end
    compared++; if (bus.res_data_o !== 32'd0) begin mismatched++; $display("FAIL reset_res_data: got %h want 0", bus.res_data_o); end
    compared++; if (bus.res_ctrl_o !== 3'b000) begin mismatched++; $display("FAIL reset_res_ctrl: got %b want 000", bus.res_ctrl_o); end
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b want 00", {bus.req1_ready_o, bus.req0_ready_o}); end
    step();
    rst = 1'b1;
    idle_reqs();
  endtask

  task automatic test_add();
    bus.res_ready_i = 1'b1;
    set_req(0, 2'b00, 6'b100000, 32'd5, 32'd7);
    @(negedge clk);
    compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin mismatched++; $display("FAIL add_ready: got %b want 01", {bus.req1_ready_o, bus.req0_ready_o}); end
    step();
    idle_reqs();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin mismatched++; $display("FAIL add_exec: got valid=%b busy=%b want valid=0 busy=1", bus.res_valid_o, bus.busy_o); end
    step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b1) begin mismatched++; $display("FAIL add_valid: got %b want 1", bus.res_valid_o); end
    compared++; if (bus.res_data_o !== 32'd12) begin mismatched++; $display("FAIL add_data: got %0d want 12", bus.res_data_o); end
    compared++; if (bus.res_id_o !== 1'b0 || bus.res_ctrl_o !== 3'b000) begin mismatched++; $display("FAIL add_id_ctrl: got id=%b ctrl=%b want id=0 ctrl=000", bus.res_id_o, bus.res_ctrl_o); end
    step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL add_idle: got valid=%b busy=%b want 0 0", bus.res_valid_o, bus.busy_o); end
    step();
  endtask

  task automatic test_mul();
    bus.res_ready_i = 1'b1;
    set_req(0, 2'b00, 6'b011000, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    compared++; if (bus.req0_ready_o !== 1'b1) begin mismatched++; $display("FAIL mul_ready: got %b want 1", bus.req0_ready_o); end
    step();
    idle_reqs();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      compared++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin mismatched++; $display("FAIL mul_exec%0d: got valid=%b busy=%b want 0 1", k, bus.res_valid_o, bus.busy_o); end
      step();
    end
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin mismatched++; $display("FAIL mul_done: got valid=%b busy=%b want 1 1", bus.res_valid_o, bus.busy_o); end
    compared++; if (bus.res_data_o !== 32'd0 || bus.res_ctrl_o !== 3'b001) begin mismatched++; $display("FAIL mul_result: got data=%h ctrl=%b want 0 001", bus.res_data_o, bus.res_ctrl_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic        exp_id;
    logic [31:0] exp_data;
    logic [1:0]  exp_rdy;
    rst = 1'b0; idle_reqs();
    step();
    rst = 1'b1;
    bus.res_ready_i = 1'b1;
    set_req(0, 2'b01, 6'b000000, 32'd100, 32'd1);
    set_req(1, 2'b10, 6'b000000, 32'd50, 32'd8);
    @(negedge clk);
    compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin mismatched++; $display("FAIL rr_first: got %b want 01", {bus.req1_ready_o, bus.req0_ready_o}); end
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin mismatched++; $display("FAIL rr_exec_ready%0d: got %b want 00", i, {bus.req1_ready_o, bus.req0_ready_o}); end
      step();
      @(negedge clk);
      exp_id   = i[0];
      exp_data = exp_id ? 32'd42 : 32'd101;
      exp_rdy  = exp_id ? 2'b01 : 2'b10;
      compared++; if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== exp_id || bus.res_data_o !== exp_data) begin mismatched++; $display("FAIL rr_result%0d: got v=%b id=%b data=%0d want 1 %b %0d", i, bus.res_valid_o, bus.res_id_o, bus.res_data_o, exp_id, exp_data); end
      compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== exp_rdy) begin mismatched++; $display("FAIL rr_b2b_ready%0d: got %b want %b", i, {bus.req1_ready_o, bus.req0_ready_o}, exp_rdy); end
      step();
    end
    idle_reqs();
    @(negedge clk);
    step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 1'b0 || bus.res_data_o !== 32'd101) begin mismatched++; $display("FAIL rr_drain: got v=%b id=%b data=%0d want 1 0 101", bus.res_valid_o, bus.res_id_o, bus.res_data_o); end
    step();
  endtask

  task automatic test_backpressure();
    bus.res_ready_i = 1'b0;
    set_req(0, 2'b00, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
    @(negedge clk);
    compared++; if (bus.req0_ready_o !== 1'b1) begin mismatched++; $display("FAIL bp_accept: got %b want 1", bus.req0_ready_o); end
    step();
    idle_reqs();
    set_req(1, 2'b00, 6'b100101, 32'h0000_000F, 32'h0000_00F0);
    @(negedge clk);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'h0000_F000 || bus.res_id_o !== 1'b0 || bus.res_ctrl_o !== 3'b011) begin mismatched++; $display("FAIL bp_hold%0d: got v=%b data=%h id=%b ctrl=%b want 1 f000 0 011", k, bus.res_valid_o, bus.res_data_o, bus.res_id_o, bus.res_ctrl_o); end
      compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin mismatched++; $display("FAIL bp_noready%0d: got %b want 00", k, {bus.req1_ready_o, bus.req0_ready_o}); end
      step();
    end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    compared++; if (bus.req1_ready_o !== 1'b1 || bus.res_valid_o !== 1'b1) begin mismatched++; $display("FAIL bp_release: got ready1=%b valid=%b want 1 1", bus.req1_ready_o, bus.res_valid_o); end
    step();
    idle_reqs();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin mismatched++; $display("FAIL bp_exec2: got valid=%b busy=%b want 0 1", bus.res_valid_o, bus.busy_o); end
    step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 1'b1 || bus.res_data_o !== 32'h0000_00FF || bus.res_ctrl_o !== 3'b100) begin mismatched++; $display("FAIL bp_second: got v=%b id=%b data=%h ctrl=%b want 1 1 ff 100", bus.res_valid_o, bus.res_id_o, bus.res_data_o, bus.res_ctrl_o); end
    step();
  endtask

  task automatic test_decode_edges();
    logic [1:0]  t_aluop [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [5:0]  t_funct [4] = '{6'b000000, 6'b011000, 6'b101010, 6'b100010};
    logic [31:0] t_a     [4] = '{32'd0, 32'd3, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] t_b     [4] = '{32'd1, 32'd4, 32'd4, 32'd2};
    logic [31:0] t_data  [4] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1};
    logic [2:0]  t_ctrl  [4] = '{3'b010, 3'b000, 3'b000, 3'b000};
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, t_aluop[i], t_funct[i], t_a[i], t_b[i]);
      @(negedge clk);
      step();
      idle_reqs();
      @(negedge clk);
      step();
      @(negedge clk);
      compared++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== t_data[i] || bus.res_ctrl_o !== t_ctrl[i]) begin mismatched++; $display("FAIL decode%0d: got v=%b data=%h ctrl=%b want 1 %h %b", i, bus.res_valid_o, bus.res_data_o, bus.res_ctrl_o, t_data[i], t_ctrl[i]); end
      step();
    end
  endtask

  task automatic test_reset_mid_exec();
    bus.res_ready_i = 1'b1;
    set_req(0, 2'b00, 6'b011000, 32'd6, 32'd7);
    @(negedge clk);
    step();
    set_req(0, 2'b01, 6'b000000, 32'd1, 32'd1);
    set_req(1, 2'b01, 6'b000000, 32'd9, 32'd9);
    rst = 1'b0;
    step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.res_data_o !== 32'd0 || bus.res_id_o !== 1'b0 || bus.res_ctrl_o !== 3'b000) begin mismatched++; $display("FAIL rstmid_outputs: got v=%b busy=%b data=%h id=%b ctrl=%b want all 0", bus.res_valid_o, bus.busy_o, bus.res_data_o, bus.res_id_o, bus.res_ctrl_o); end
    compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin mismatched++; $display("FAIL rstmid_ready: got %b want 00", {bus.req1_ready_o, bus.req0_ready_o}); end
    step();
    idle_reqs();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++; if (bus.res_valid_o !== 1'b0) begin mismatched++; $display("FAIL rstmid_noresult%0d: got %b want 0", k, bus.res_valid_o); end
      step();
    end
    set_req(0, 2'b01, 6'b000000, 32'd1, 32'd1);
    set_req(1, 2'b01, 6'b000000, 32'd9, 32'd9);
    @(negedge clk);
    compared++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin mismatched++; $display("FAIL rstmid_tie: got %b want 01", {bus.req1_ready_o, bus.req0_ready_o}); end
    step();
    idle_reqs();
    @(negedge clk);
    step();
    @(negedge clk);
    compared++; if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 1'b0 || bus.res_data_o !== 32'd2) begin mismatched++; $display("FAIL rstmid_after: got v=%b id=%b data=%0d want 1 0 2", bus.res_valid_o, bus.res_id_o, bus.res_data_o); end
    step();
  endtask

  initial begin
    bus.res_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b0; bus.req0_funct_i = '0; bus.req0_aluop_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_funct_i = '0; bus.req1_aluop_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0;
    #1;
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_decode_edges();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
